// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (priority, pass-through)
// and a DMA/loader port that steals idle slots or forces a short burst after a bounded wait.
module dmem_arbiter #(
   parameter int unsigned MAX_WAIT  = 8,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_read,
   input  logic        c_write,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic [31:0] c_rdata,
   output logic        c_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_read,
   output logic        m_write,
   input  logic [31:0] m_rdata,
   output logic        dma_burst
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam int unsigned BW = $clog2(BURST_MAX + 1);

   typedef enum logic {
      ST_SHARE = 1'b0,
      ST_FORCE = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            cpu_act;

   assign cpu_act = c_read | c_write;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_SHARE;
         wait_cnt_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Grant, memory steering and next state are all combinational from inputs + state.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      burst_cnt_d = burst_cnt_q;
      c_stall     = 1'b0;
      d_ack       = 1'b0;
      m_addr      = c_addr;
      m_wdata     = c_wdata;
      m_read      = 1'b0;
      m_write     = 1'b0;

      if (state_q == ST_FORCE && d_req) begin
         c_stall = 1'b1;
         d_ack   = 1'b1;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         m_read  = ~d_we;
         m_write = d_we;
         if (burst_cnt_q < BW'(BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
         end
         if (burst_cnt_d == BW'(BURST_MAX)) begin
            state_d = ST_SHARE;
         end
      end else begin
         // An idle DMA port ends a forced burst early; wait_cnt is left alone.
         if (state_q == ST_FORCE) begin
            state_d = ST_SHARE;
         end
         if (cpu_act) begin
            m_read  = ~c_write;
            m_write = c_write;
            if (d_req && state_q == ST_SHARE) begin
               if (wait_cnt_q < WW'(MAX_WAIT)) begin
                  wait_cnt_d = wait_cnt_q + WW'(1);
               end
               if (wait_cnt_d == WW'(MAX_WAIT)) begin
                  state_d     = ST_FORCE;
                  wait_cnt_d  = '0;
                  burst_cnt_d = '0;
               end
            end
         end else if (d_req) begin
            d_ack      = 1'b1;
            m_addr     = d_addr;
            m_wdata    = d_wdata;
            m_read     = ~d_we;
            m_write    = d_we;
            wait_cnt_d = '0;
         end
      end

      // No grant and no memory access while reset is held.
      if (!reset) begin
         c_stall = 1'b0;
         d_ack   = 1'b0;
         m_read  = 1'b0;
         m_write = 1'b0;
      end
   end

   assign dma_burst = reset & (state_q == ST_FORCE);
   assign c_rdata   = m_rdata;
   assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word memory model behind the m_* port.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_read, c_write;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic        c_stall;
   logic        d_req, d_we, d_ack;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_read, m_write, dma_burst;

   logic [31:0] mem [64];
   logic        tb_we;
   logic [5:0]  tb_idx;
   logic [31:0] tb_d;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(8), .BURST_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_stall(c_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
      .m_rdata(m_rdata), .dma_burst(dma_burst)
   );

   // Memory model: combinational read, write at the cycle-ending edge; tb port for preload.
   assign m_rdata = mem[m_addr[7:2]];
   always @(posedge clk) begin
      if (tb_we) mem[tb_idx] <= tb_d;
      else if (m_write) mem[m_addr[7:2]] <= m_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic ea, eb;
      int   k;
      reset = 1'b0; c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      tb_we = 1'b0; tb_idx = '0; tb_d = '0;

      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         tb_we = 1'b1; tb_idx = 6'(i); tb_d = (i == 16) ? 32'h1234_5678 : 32'h0;
      end

      // Reset held with both ports requesting: nothing granted, nothing written.
      @(negedge clk);
      tb_we = 1'b0;
      c_write = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEAD_BEEF;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h55;
      #1;
      chk("rst_m_write", 32'(m_write), 32'd0);
      chk("rst_m_read", 32'(m_read), 32'd0);
      chk("rst_d_ack", 32'(d_ack), 32'd0);
      chk("rst_c_stall", 32'(c_stall), 32'd0);
      chk("rst_dma_burst", 32'(dma_burst), 32'd0);
      @(negedge clk);
      chk("rst_no_write", mem[4], 32'h0);
      chk("rst_no_dma_write", mem[32], 32'h0);

      // Reset released: CPU write goes straight through.
      reset = 1'b1; d_req = 1'b0;
      #1;
      chk("cw_m_write", 32'(m_write), 32'd1);
      chk("cw_m_addr", m_addr, 32'h10);
      chk("cw_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("cw_c_stall", 32'(c_stall), 32'd0);
      @(negedge clk);
      chk("cw_mem", mem[4], 32'hDEAD_BEEF);

      // CPU idle: DMA read steals the slot in the same cycle.
      c_write = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      #1;
      chk("dr_ack", 32'(d_ack), 32'd1);
      chk("dr_rdata", d_rdata, 32'h1234_5678);
      chk("dr_c_stall", 32'(c_stall), 32'd0);
      chk("dr_m_read", 32'(m_read), 32'd1);
      chk("dr_m_addr", m_addr, 32'h40);

      // CPU reads every cycle; 6 DMA writes: lost 0-7, burst 8-11, lost 12-19, burst 20-21, drop 22.
      k = 0;
      for (int cyc = 0; cyc < 24; cyc++) begin
         @(negedge clk);
         c_read = 1'b1; c_addr = 32'h40;
         d_req = (k < 6); d_we = 1'b1; d_addr = 32'h20 + 32'(4 * k); d_wdata = 32'hA0 + 32'(k);
         #1;
         ea = (cyc >= 8 && cyc <= 11) || cyc == 20 || cyc == 21;
         eb = (cyc >= 8 && cyc <= 11) || (cyc >= 20 && cyc <= 22);
         chk($sformatf("sat_ack_c%0d", cyc), 32'(d_ack), 32'(ea));
         chk($sformatf("sat_stall_c%0d", cyc), 32'(c_stall), 32'(ea));
         chk($sformatf("sat_burst_c%0d", cyc), 32'(dma_burst), 32'(eb));
         chk($sformatf("sat_mwr_c%0d", cyc), 32'(m_write), 32'(ea));
         chk($sformatf("sat_mrd_c%0d", cyc), 32'(m_read), 32'(!ea));
         if (!ea) chk($sformatf("sat_crdata_c%0d", cyc), c_rdata, 32'h1234_5678);
         if (ea) k++;
      end
      @(negedge clk);
      for (int i = 0; i < 6; i++) chk($sformatf("dma_mem_%0d", i), mem[8 + i], 32'hA0 + 32'(i));

      // Reset pulsed during the second cycle of a forced burst.
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc > 0) @(negedge clk);
         c_read = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
         if (cyc == 9) reset = 1'b0;
         #1;
         chk($sformatf("rf_ack_c%0d", cyc), 32'(d_ack), 32'(cyc == 8));
         chk($sformatf("rf_stall_c%0d", cyc), 32'(c_stall), 32'(cyc == 8));
         chk($sformatf("rf_burst_c%0d", cyc), 32'(dma_burst), 32'(cyc == 8));
      end
      chk("rf_m_read_in_rst", 32'(m_read), 32'd0);

      // After reset the DMA needs 8 fresh lost cycles; then drops d_req in FORCE.
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         reset = 1'b1; c_read = 1'b1; d_req = (cyc <= 8);
         #1;
         chk($sformatf("ra_ack_c%0d", cyc), 32'(d_ack), 32'(cyc == 8));
         chk($sformatf("ra_burst_c%0d", cyc), 32'(dma_burst), 32'(cyc >= 8));
         chk($sformatf("ra_stall_c%0d", cyc), 32'(c_stall), 32'(cyc == 8));
      end
      chk("ra_cpu_read_on_drop", 32'(m_read), 32'd1);

      // wait_cnt survives a request dropped before ack: 4 lost, 2 idle, 4 lost, ack cycle 10.
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         c_read = 1'b1; d_req = !(cyc == 4 || cyc == 5 || cyc == 11);
         #1;
         chk($sformatf("wr_ack_c%0d", cyc), 32'(d_ack), 32'(cyc == 10));
         chk($sformatf("wr_burst_c%0d", cyc), 32'(dma_burst), 32'(cyc >= 10));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline's MEM-stage access port and a DMA/loader port (UART loader, peripheral DMA). The CPU port has priority and sees combinational pass-through; the DMA port steals idle slots and, after a bounded wait, forces a short burst by stalling the pipeline. Sits between the CPU's MEM stage and the data memory instance.

## Interface
- MAX_WAIT, 8, DMA lost-arbitration cycles tolerated before a forced burst (≥1)
- BURST_MAX, 4, max DMA accesses served per forced burst (≥1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- c_read  in  1  CPU read request this cycle
- c_write  in  1  CPU write request this cycle (wins if both c_read and c_write are high)
- c_addr  in  32  CPU byte address
- c_wdata  in  32  CPU write data
- c_rdata  out  32  CPU read data, combinational from m_rdata
- c_stall  out  1  pipeline must freeze; CPU access not performed this cycle
- d_req  in  1  DMA request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  DMA write (1) / read (0)
- d_addr  in  32  DMA byte address
- d_wdata  in  32  DMA write data
- d_ack  out  1  DMA access performed this cycle (combinational)
- d_rdata  out  32  DMA read data, valid when d_ack=1
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_read  out  1  memory read enable
- m_write  out  1  memory write enable (committed at cycle-ending edge)
- m_rdata  in  32  memory combinational read data
- dma_burst  out  1  status: FSM in FORCE

## Operation
- FSM states: SHARE (reset state), FORCE.
- Registers: wait_cnt (0..MAX_WAIT), burst_cnt (0..BURST_MAX), saturating, never wrap.
- SHARE, CPU active (c_read|c_write): CPU granted; m_* = CPU fields; d_ack=0; if d_req, wait_cnt+1.
- SHARE, CPU idle, d_req=1: DMA granted; d_ack=1; m_* = DMA fields; wait_cnt←0.
- SHARE, nothing requested: m_read=m_write=0, m_addr/m_wdata = c_addr/c_wdata.
- SHARE→FORCE at the edge where incremented wait_cnt reaches MAX_WAIT; burst_cnt←0, wait_cnt←0.
- FORCE, d_req=1: c_stall=1, DMA granted, d_ack=1, burst_cnt+1; if new burst_cnt==BURST_MAX → SHARE.
- FORCE, d_req=0: c_stall=0, cycle arbitrated exactly as SHARE with wait_cnt unchanged; → SHARE.
- c_stall is 0 in SHARE under all inputs; the CPU is never denied outside FORCE.
- c_rdata and d_rdata both drive m_rdata; meaningful only for the granted port.
- Write issued on granted port only; a stalled CPU write is not issued and must be re-presented by the frozen pipeline.

## Timing
- Reset (reset=0, asynchronous): state=SHARE, wait_cnt=0, burst_cnt=0; c_stall=0, d_ack=0, dma_burst=0, m_read=0, m_write=0 forced combinationally while reset=0 regardless of inputs.
- Reset asserted mid-burst: burst abandoned; DMA must re-request; no write issued in reset cycles.
- Grant, d_ack, c_stall, m_* are combinational from inputs + state: zero-cycle latency, single-cycle accesses.
- Worst-case DMA latency with CPU saturating: MAX_WAIT lost cycles, acked in cycle MAX_WAIT (0-based from first d_req).
- Worst-case CPU stall per forced burst: BURST_MAX consecutive cycles; next forced burst needs another MAX_WAIT lost DMA cycles.
- DMA handshake: access completes in the d_ack cycle; requester may present the next request in the following cycle (back-to-back permitted).
- d_req dropped before ack: wait_cnt retains value (not cleared).

## Test plan
- Reset=0 with c_write=1, d_req=1 -> m_write=0, d_ack=0, c_stall=0; release reset -> CPU write at addr 0x10 data 0xDEADBEEF issued next cycle.
- CPU idle, DMA read 0x40 (mem holds 0x12345678) -> d_ack=1 same cycle, d_rdata=0x12345678, c_stall=0, wait_cnt=0.
- CPU read every cycle, d_req held from cycle 0 (defaults) -> d_ack=0 cycles 0–7; cycle 8 d_ack=1, c_stall=1, dma_burst=1.
- Continued: d_req held with 6 writes queued -> 4 acks cycles 8–11 with c_stall=1; cycle 12 c_stall=0, CPU granted, remaining 2 wait.
- In FORCE after 2 acks, drop d_req -> c_stall=0 that cycle, CPU access performed, state SHARE next cycle.
- Reset pulsed low during FORCE cycle 9 -> c_stall=0 immediately, dma_burst=0, next forced burst only after 8 new lost cycles.
